// File: rtl/apb_fifo_port.sv
// APB slave exposing NCH external FIFO channels as DATA / STATUS / CNT registers.
// Blocked FIFO accesses wait in WAIT until the FIFO is ready or the timeout expires.
module apb_fifo_port #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LVLW  = 5,
    parameter logic [31:0] BASE  = 32'h2000_0000,
    parameter int unsigned TMO   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [NCH-1:0]       wr_en,
    output logic [WIDTH-1:0]     wr_data,
    output logic [NCH-1:0]       rd_en,
    input  logic [NCH*WIDTH-1:0] rd_data,
    input  logic [NCH-1:0]       fifo_full,
    input  logic [NCH-1:0]       fifo_empty,
    input  logic [NCH*LVLW-1:0]  fifo_level
);

    localparam int unsigned CNTW = 16;
    localparam int unsigned TMOW = 8;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        EVAL  = 5'b00010,
        WAIT  = 5'b00100,
        RDLAT = 5'b01000,
        RESP  = 5'b10000
    } state_t;

    state_t              state_q, state_d;
    logic [TMOW-1:0]     tmo_q, tmo_d;
    logic [NCH*CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]         prdata_q, prdata_d;
    logic                rd_pass_q, rd_pass_d;
    logic                pready_d, pslverr_d;
    logic [NCH-1:0]      wr_en_d, rd_en_d;
    logic [WIDTH-1:0]    wr_data_d;
    logic                cnt_inc, cnt_clr, act;

    // Address decode and per-channel status selection
    logic [31:0]      rel;
    logic [1:0]       ch;
    logic [3:0]       off;
    logic             dec_err, is_stat, is_cnt, blocked;
    logic [NCH-1:0]   ch_oh;
    logic             full_sel, empty_sel;
    logic [LVLW-1:0]  lvl_sel;
    logic [CNTW-1:0]  cnt_sel;
    logic [WIDTH-1:0] rd_sel;

    always_comb begin
        rel       = paddr - BASE;
        ch        = rel[5:4];
        off       = rel[3:0];
        ch_oh     = '0;
        full_sel  = 1'b0;
        empty_sel = 1'b0;
        lvl_sel   = '0;
        cnt_sel   = '0;
        rd_sel    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch == 2'(i)) begin
                ch_oh[i]  = 1'b1;
                full_sel  = fifo_full[i];
                empty_sel = fifo_empty[i];
                lvl_sel   = fifo_level[i*LVLW +: LVLW];
                cnt_sel   = cnt_q[i*CNTW +: CNTW];
                rd_sel    = rd_data[i*WIDTH +: WIDTH];
            end
        end
        dec_err = (rel[31:4] >= 28'(NCH)) || (off[1:0] != 2'd0) || (off[3:2] == 2'd3)
                  || ((off[3:2] == 2'd1) && pwrite);
        is_stat = (off[3:2] == 2'd1);
        is_cnt  = (off[3:2] == 2'd2);
        blocked = pwrite ? full_sel : empty_sel;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        rd_pass_d = 1'b0;
        wr_en_d   = '0;
        rd_en_d   = '0;
        wr_data_d = wr_data;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        act       = 1'b0;
        case (state_q)
            IDLE: if (psel && penable && !pready) state_d = EVAL;
            EVAL: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (dec_err) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (is_stat) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    prdata_d = 32'({full_sel, empty_sel, lvl_sel});
                end else if (is_cnt) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    if (pwrite) cnt_clr = 1'b1;
                    else        prdata_d = 32'(cnt_sel);
                end else if (blocked) begin
                    state_d = WAIT;
                    tmo_d   = TMOW'(TMO);
                end else begin
                    act = 1'b1;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (!blocked) begin
                    act   = 1'b1;
                    tmo_d = '0;
                end else if (tmo_q <= TMOW'(1)) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q - TMOW'(1);
                end
            end
            RDLAT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    rd_pass_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (act) begin
            if (pwrite) begin
                wr_en_d   = ch_oh;
                wr_data_d = WIDTH'(pwdata);
                cnt_inc   = 1'b1;
                state_d   = RESP;
                pready_d  = 1'b1;
            end else begin
                rd_en_d = ch_oh;
                state_d = RDLAT;
            end
        end
    end

    // Push counters: a clear takes priority over an increment on the same channel
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_oh[i]) begin
                if (cnt_clr)      cnt_d[i*CNTW +: CNTW] = '0;
                else if (cnt_inc) cnt_d[i*CNTW +: CNTW] = cnt_q[i*CNTW +: CNTW] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            rd_pass_q <= 1'b0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            wr_en     <= '0;
            rd_en     <= '0;
            wr_data   <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            rd_pass_q <= rd_pass_d;
            pready    <= pready_d;
            pslverr   <= pslverr_d;
            wr_en     <= wr_en_d;
            rd_en     <= rd_en_d;
            wr_data   <= wr_data_d;
        end
    end

    // Popped data arrives from the FIFO's own output register in the response cycle
    assign prdata = rd_pass_q ? 32'(rd_sel) : prdata_q;

endmodule

// File: tb/tb_apb_fifo_port.sv
// Bench for apb_fifo_port: directed scenarios plus random APB traffic scored
// against a queue-based model of the register map and attached FIFOs.
module tb_apb_fifo_port;

    localparam int          NCH   = 2;
    localparam int          WIDTH = 32;
    localparam int          LVLW  = 5;
    localparam int          TMO   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h2000_0000;

    logic                 clk, rst_n;
    logic                 psel, penable, pwrite;
    logic [31:0]          paddr, pwdata, prdata;
    logic                 pready, pslverr;
    logic [NCH-1:0]       wr_en, rd_en;
    logic [WIDTH-1:0]     wr_data;
    logic [NCH*WIDTH-1:0] rd_data;
    logic [NCH-1:0]       fifo_full, fifo_empty;
    logic [NCH*LVLW-1:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;

    apb_fifo_port #(.NCH(NCH), .WIDTH(WIDTH), .LVLW(LVLW), .BASE(BASE), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FIFO model with registered pop data
    logic [31:0] fq0[$], fq1[$];
    int          sz0 = 0, sz1 = 0;
    logic [31:0] rd0 = '0, rd1 = '0;
    logic [1:0]  full_ovr = '0, empty_ovr = '0;

    always @(posedge clk) begin
        if (wr_en[0]) fq0.push_back(wr_data);
        if (wr_en[1]) fq1.push_back(wr_data);
        if (rd_en[0]) begin
            if (fq0.size() > 0) rd0 <= fq0.pop_front();
            else                rd0 <= 32'hDEAD_BEEF;
        end
        if (rd_en[1]) begin
            if (fq1.size() > 0) rd1 <= fq1.pop_front();
            else                rd1 <= 32'hDEAD_BEEF;
        end
        sz0 = fq0.size();
        sz1 = fq1.size();
    end

    assign rd_data    = {rd1, rd0};
    assign fifo_full  = {full_ovr[1] | (sz1 >= DEPTH), full_ovr[0] | (sz0 >= DEPTH)};
    assign fifo_empty = {empty_ovr[1] | (sz1 == 0), empty_ovr[0] | (sz0 == 0)};
    assign fifo_level = {5'(sz1), 5'(sz0)};

    // Strobe monitor: counts pulses and records the last strobe seen
    int          wr_cnt = 0, rd_cnt = 0, rdy_cnt = 0, onehot_viol = 0;
    logic [1:0]  wr_oh_seen = '0, rd_oh_seen = '0;
    logic [31:0] wr_data_seen = '0;

    always @(posedge clk) begin
        if (wr_en != '0) begin
            wr_cnt++;
            wr_oh_seen   = wr_en;
            wr_data_seen = wr_data;
        end
        if (rd_en != '0) begin
            rd_cnt++;
            rd_oh_seen = rd_en;
        end
        if (pready) rdy_cnt++;
        if ($countones(wr_en | rd_en) > 1) onehot_viol++;
    end

    // Expected FIFO contents and push counters
    logic [31:0] sc[2][$];
    logic [15:0] cnt_m[2];

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; rdata = '0; err = 1'b0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rdata; logic err; int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pready, pslverr, prdata, wr_en, rd_en, wr_data} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b err=%b prdata=%h wr_en=%b rd_en=%b wr_data=%h want all 0",
                     pready, pslverr, prdata, wr_en, rd_en, wr_data);
            miscompares++;
        end
        rst_n = 1'b1;
        cnt_m[0] = '0; cnt_m[1] = '0;
        for (int c = 0; c < NCH; c++) begin
            apb(1'b0, BASE + 32'(c) * 32'h10 + 32'h8, '0, rdata, err, lat);
            vectors++;
            if (rdata !== 32'h0 || err !== 1'b0) begin
                $display("FAIL reset_cnt%0d: got %h err=%b want 0 err=0", c, rdata, err);
                miscompares++;
            end
        end
    endtask

    task automatic test_write_ch1();
        logic [31:0] rdata; logic err; int lat; int w0;
        w0 = wr_cnt;
        apb(1'b1, BASE + 32'h10, 32'hA5A5_0001, rdata, err, lat);
        sc[1].push_back(32'hA5A5_0001);
        cnt_m[1]++;
        vectors++;
        if (lat !== 2 || err !== 1'b0) begin
            $display("FAIL write_ch1_resp: got lat=%0d err=%b want lat=2 err=0", lat, err);
            miscompares++;
        end
        vectors++;
        if (wr_cnt - w0 !== 1 || wr_oh_seen !== 2'b10 || wr_data_seen !== 32'hA5A5_0001) begin
            $display("FAIL write_ch1_strobe: got pulses=%0d wr_en=%b data=%h want 1 10 a5a50001",
                     wr_cnt - w0, wr_oh_seen, wr_data_seen);
            miscompares++;
        end
        apb(1'b0, BASE + 32'h18, '0, rdata, err, lat);
        vectors++;
        if (rdata !== 32'h1 || lat !== 2) begin
            $display("FAIL write_ch1_cnt: got %h lat=%0d want 1 lat=2", rdata, lat);
            miscompares++;
        end
    endtask

    task automatic test_read_ch0();
        logic [31:0] rdata; logic err; int lat; int r0;
        apb(1'b1, BASE, 32'h1234, rdata, err, lat);
        sc[0].push_back(32'h1234);
        cnt_m[0]++;
        r0 = rd_cnt;
        apb(1'b0, BASE, '0, rdata, err, lat);
        void'(sc[0].pop_front());
        vectors++;
        if (lat !== 3 || err !== 1'b0 || rdata !== 32'h1234) begin
            $display("FAIL read_ch0: got lat=%0d err=%b data=%h want 3 0 00001234", lat, err, rdata);
            miscompares++;
        end
        vectors++;
        if (rd_cnt - r0 !== 1 || rd_oh_seen !== 2'b01) begin
            $display("FAIL read_ch0_strobe: got pulses=%0d rd_en=%b want 1 01", rd_cnt - r0, rd_oh_seen);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rdata; logic err; int lat; int w0, r0;
        full_ovr[0] = 1'b1;
        w0 = wr_cnt;
        apb(1'b1, BASE, 32'hCAFE_0000, rdata, err, lat);
        vectors++;
        if (lat !== 2 + TMO || err !== 1'b1 || rdata !== 32'h0 || wr_cnt - w0 !== 0) begin
            $display("FAIL timeout_write: got lat=%0d err=%b data=%h pulses=%0d want %0d 1 0 0",
                     lat, err, rdata, wr_cnt - w0, 2 + TMO);
            miscompares++;
        end
        w0 = wr_cnt;
        fork
            apb(1'b1, BASE, 32'hCAFE_0001, rdata, err, lat);
            begin
                wait (penable === 1'b1);
                repeat (3) @(posedge clk);
                #1 full_ovr[0] = 1'b0;
            end
        join
        sc[0].push_back(32'hCAFE_0001);
        cnt_m[0]++;
        vectors++;
        if (err !== 1'b0 || wr_cnt - w0 !== 1 || wr_data_seen !== 32'hCAFE_0001 || lat < 3 || lat > 2 + TMO) begin
            $display("FAIL timeout_clear: got err=%b pulses=%0d data=%h lat=%0d want 0 1 cafe0001 3..%0d",
                     err, wr_cnt - w0, wr_data_seen, lat, 2 + TMO);
            miscompares++;
        end
        empty_ovr[1] = 1'b1;
        r0 = rd_cnt;
        apb(1'b0, BASE + 32'h10, '0, rdata, err, lat);
        empty_ovr[1] = 1'b0;
        vectors++;
        if (lat !== 2 + TMO || err !== 1'b1 || rdata !== 32'h0 || rd_cnt - r0 !== 0) begin
            $display("FAIL timeout_read: got lat=%0d err=%b data=%h pulses=%0d want %0d 1 0 0",
                     lat, err, rdata, rd_cnt - r0, 2 + TMO);
            miscompares++;
        end
    endtask

    task automatic test_decode_err();
        logic [31:0] rdata; logic err; int lat; int w0, r0;
        logic [31:0] addrs[5];
        logic        wrs[5];
        addrs = '{BASE + 32'h20, BASE + 32'h04, BASE + 32'h02, BASE + 32'h0C, BASE - 32'h10};
        wrs   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            w0 = wr_cnt; r0 = rd_cnt;
            apb(wrs[i], addrs[i], 32'h5555_AAAA, rdata, err, lat);
            vectors++;
            if (lat !== 2 || err !== 1'b1 || rdata !== 32'h0 || wr_cnt != w0 || rd_cnt != r0) begin
                $display("FAIL decode_err_%h: got lat=%0d err=%b data=%h strobes=%0d want 2 1 0 0",
                         addrs[i], lat, err, rdata, (wr_cnt - w0) + (rd_cnt - r0));
                miscompares++;
            end
        end
    endtask

    task automatic test_cnt_wrap();
        logic [31:0] rdata; logic err; int lat;
        force dut.cnt_q = {cnt_m[1], 16'hFFFF};
        @(posedge clk); #1;
        release dut.cnt_q;
        cnt_m[0] = 16'hFFFF;
        apb(1'b0, BASE + 32'h8, '0, rdata, err, lat);
        vectors++;
        if (rdata !== 32'h0000_FFFF) begin
            $display("FAIL cnt_preset: got %h want 0000ffff", rdata);
            miscompares++;
        end
        apb(1'b1, BASE, 32'h0BAD_F00D, rdata, err, lat);
        sc[0].push_back(32'h0BAD_F00D);
        cnt_m[0]++;
        apb(1'b0, BASE + 32'h8, '0, rdata, err, lat);
        vectors++;
        if (rdata !== 32'(cnt_m[0]) || rdata !== 32'h0) begin
            $display("FAIL cnt_wrap: got %h want 00000000", rdata);
            miscompares++;
        end
        apb(1'b1, BASE + 32'h10, 32'h0000_0777, rdata, err, lat);
        sc[1].push_back(32'h0000_0777);
        apb(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, rdata, err, lat);
        cnt_m[1] = '0;
        apb(1'b0, BASE + 32'h18, '0, rdata, err, lat);
        vectors++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
            $display("FAIL cnt_clear: got %h err=%b want 0 err=0", rdata, err);
            miscompares++;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rdata; logic err; int lat; int w0, y0;
        full_ovr[0] = 1'b1;
        w0 = wr_cnt; y0 = rdy_cnt;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE; pwdata = 32'h0DD0_0DD0;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; full_ovr[0] = 1'b0;
        repeat (2 * TMO) @(posedge clk);
        #1;
        vectors++;
        if (wr_cnt != w0 || rdy_cnt != y0) begin
            $display("FAIL abort_psel: got pulses=%0d ready=%0d want 0 0", wr_cnt - w0, rdy_cnt - y0);
            miscompares++;
        end
        full_ovr[0] = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE; pwdata = 32'h0DD0_0DD1;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({pready, pslverr, prdata, wr_en, rd_en, wr_data} !== '0) begin
            $display("FAIL reset_in_wait: got rdy=%b err=%b prdata=%h wr_en=%b rd_en=%b wr_data=%h want all 0",
                     pready, pslverr, prdata, wr_en, rd_en, wr_data);
            miscompares++;
        end
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0; full_ovr[0] = 1'b0;
        cnt_m[0] = '0; cnt_m[1] = '0;
        w0 = wr_cnt;
        apb(1'b1, BASE + 32'h10, 32'h1357_9BDF, rdata, err, lat);
        sc[1].push_back(32'h1357_9BDF);
        cnt_m[1]++;
        vectors++;
        if (lat !== 2 || err !== 1'b0 || wr_cnt - w0 !== 1 || wr_oh_seen !== 2'b10) begin
            $display("FAIL after_reset_write: got lat=%0d err=%b pulses=%0d wr_en=%b want 2 0 1 10",
                     lat, err, wr_cnt - w0, wr_oh_seen);
            miscompares++;
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] rdata, exp_d, wd, addr; logic err, exp_err, wr; int lat, exp_lat;
        int kind, ch, w0, r0, exp_w, exp_r, sz;
        logic [31:0] eaddrs[4];
        eaddrs = '{BASE + 32'h20, BASE + 32'h1C, BASE + 32'h11, BASE + 32'h1000};
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 5));
            ch   = int'($urandom_range(0, 1));
            wd   = $urandom;
            sz   = sc[ch].size();
            exp_d = '0; exp_err = 1'b0; exp_lat = 2; exp_w = 0; exp_r = 0;
            case (kind)
                0: begin
                    wr = 1'b1; addr = BASE + 32'(ch) * 32'h10;
                    if (sz >= DEPTH) begin exp_err = 1'b1; exp_lat = 2 + TMO; end
                    else begin exp_w = 1; sc[ch].push_back(wd); cnt_m[ch]++; end
                end
                1: begin
                    wr = 1'b0; addr = BASE + 32'(ch) * 32'h10;
                    if (sz == 0) begin exp_err = 1'b1; exp_lat = 2 + TMO; end
                    else begin exp_r = 1; exp_lat = 3; exp_d = sc[ch].pop_front(); end
                end
                2: begin
                    wr = 1'b0; addr = BASE + 32'(ch) * 32'h10 + 32'h4;
                    exp_d = 32'(((sz >= DEPTH) ? 64 : 0) + ((sz == 0) ? 32 : 0) + sz);
                end
                3: begin
                    wr = 1'b0; addr = BASE + 32'(ch) * 32'h10 + 32'h8;
                    exp_d = 32'(cnt_m[ch]);
                end
                4: begin
                    wr = 1'b1; addr = BASE + 32'(ch) * 32'h10 + 32'h8;
                    cnt_m[ch] = '0;
                end
                default: begin
                    wr = wd[0]; addr = eaddrs[wd[2:1]]; exp_err = 1'b1;
                end
            endcase
            w0 = wr_cnt; r0 = rd_cnt;
            apb(wr, addr, wd, rdata, err, lat);
            vectors++;
            if (lat !== exp_lat || err !== exp_err || rdata !== exp_d) begin
                $display("FAIL rand%0d_resp addr=%h wr=%b: got lat=%0d err=%b data=%h want %0d %b %h",
                         i, addr, wr, lat, err, rdata, exp_lat, exp_err, exp_d);
                miscompares++;
            end
            vectors++;
            if (wr_cnt - w0 !== exp_w || rd_cnt - r0 !== exp_r) begin
                $display("FAIL rand%0d_strobes: got wr=%0d rd=%0d want %0d %0d",
                         i, wr_cnt - w0, rd_cnt - r0, exp_w, exp_r);
                miscompares++;
            end
            if (exp_w == 1) begin
                vectors++;
                if (wr_data_seen !== wd || wr_oh_seen !== 2'(1 << ch)) begin
                    $display("FAIL rand%0d_push: got data=%h wr_en=%b want %h %b",
                             i, wr_data_seen, wr_oh_seen, wd, 2'(1 << ch));
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        test_reset();
        test_write_ch1();
        test_read_ch0();
        test_timeout();
        test_decode_err();
        test_cnt_wrap();
        test_abort();
        test_random(250);
        vectors++;
        if (onehot_viol !== 0) begin
            $display("FAIL strobe_onehot: got %0d multi-strobe cycles want 0", onehot_viol);
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
